// File: rtl/aud_i2s_receiver_if.sv
// Sample write bus from the I2S capture path
// toward the recorder / SRAM side.
interface aud_i2s_receiver_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W-1:0] o_address;
  logic              o_valid;
  logic [ADDR_W:0]   o_len;
  logic              o_full;

  modport master (
    output o_data,
    output o_address,
    output o_valid,
    output o_len,
    output o_full
  );

  modport slave (
    input o_data,
    input o_address,
    input o_valid,
    input o_len,
    input o_full
  );
endinterface

// File: rtl/aud_i2s_receiver.sv
// WM8731 ADC capture: oversamples BCLK/ADCLRCK/ADCDAT,
// deserialises left I2S words, strobes them to SRAM.
module aud_i2s_receiver #(
  parameter int               DATA_W      = 16,
  parameter int               ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = {ADDR_W{1'b1}},
  parameter int               SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_stop,
  input  logic               i_aud_bclk,
  input  logic               i_aud_lrc,
  input  logic               i_aud_adcdat,
  aud_i2s_receiver_if.master wr,
  output logic [2:0]         o_state
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    SKIP  = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lrc_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   bclk_q;
  logic                   lrc_last;

  logic bclk_s;
  logic lrc_s;
  logic dat_s;
  logic rise;
  logic frame_start;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] word_n;
  logic              last_bit;
  logic              at_max;

  logic clr_rec;
  logic clr_cnt;
  logic shift_en;
  logic load;
  logic commit;

  assign bclk_s = bclk_sr[SYNC_STAGES-1];
  assign lrc_s  = lrc_sr[SYNC_STAGES-1];
  assign dat_s  = dat_sr[SYNC_STAGES-1];

  assign rise        = bclk_s & ~bclk_q;
  assign frame_start = rise & ~lrc_s & lrc_last;

  assign word_n   = {shreg, dat_s};
  assign last_bit = (cnt == CNT_W'(DATA_W - 1));
  assign at_max   = (wr.o_address == MAX_ADDR);

  assign o_state = state;

  // Synchronise codec lines; remember LRC at the last BCLK rise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sr  <= '0;
      lrc_sr   <= '0;
      dat_sr   <= '0;
      bclk_q   <= 1'b0;
      lrc_last <= 1'b0;
    end else begin
      bclk_sr <= {bclk_sr[SYNC_STAGES-2:0], i_aud_bclk};
      lrc_sr  <= {lrc_sr[SYNC_STAGES-2:0], i_aud_lrc};
      dat_sr  <= {dat_sr[SYNC_STAGES-2:0], i_aud_adcdat};
      bclk_q  <= bclk_s;
      if (rise) begin
        lrc_last <= lrc_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and datapath controls; stop > pause > start.
  // HOLD is the strobe cycle, so control pulses there
  // only act after the write is committed.
  always_comb begin
    state_n  = state;
    clr_rec  = 1'b0;
    clr_cnt  = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_stop && i_start) begin
          clr_rec = 1'b1;
          state_n = SYNC;
        end
      end
      SYNC: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (i_pause) begin
          state_n = PAUSE;
        end else if (frame_start) begin
          state_n = SKIP;
        end
      end
      SKIP: begin
        clr_cnt = 1'b1;
        if (i_stop) begin
          state_n = IDLE;
        end else if (i_pause) begin
          state_n = PAUSE;
        end else begin
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (i_pause) begin
          state_n = PAUSE;
        end else if (rise) begin
          shift_en = 1'b1;
          if (last_bit) begin
            load    = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        commit = 1'b1;
        if (i_stop || at_max) begin
          state_n = IDLE;
        end else if (i_pause) begin
          state_n = PAUSE;
        end else begin
          state_n = SYNC;
        end
      end
      PAUSE: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (i_start) begin
          state_n = SYNC;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and write-bus registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt          <= '0;
      shreg        <= '0;
      wr.o_data    <= '0;
      wr.o_address <= '0;
      wr.o_valid   <= 1'b0;
      wr.o_len     <= '0;
      wr.o_full    <= 1'b0;
    end else begin
      wr.o_valid <= load;
      if (clr_cnt) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (shift_en) begin
        shreg <= word_n[DATA_W-2:0];
      end
      if (load) begin
        wr.o_data <= word_n;
      end
      if (clr_rec) begin
        wr.o_address <= '0;
        wr.o_len     <= '0;
        wr.o_full    <= 1'b0;
      end else if (commit) begin
        wr.o_len <= wr.o_len + LEN_W'(1);
        if (at_max) begin
          wr.o_full <= 1'b1;
        end else begin
          wr.o_address <= wr.o_address + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/aud_i2s_receiver.md
Name: aud_i2s_receiver

Overview:
- Capture side of the WM8731 digital audio link; the counterpart of the DAC-side player, which serialises samples onto AUD_DACDAT.
- Oversamples the codec-mastered BCLK, ADCLRCK and ADCDAT on the 12 MHz system clock and deserialises the left-channel I2S word into 16-bit samples.
- Emits one write strobe per sample, with a sequential SRAM address, toward the recorder/SRAM path.
- Provides record, pause and stop control driven by the debounced key pulses.

Parameters:
- DATA_W, 16, sample width in bits (MSB first on the wire).
- ADDR_W, 20, sample address width (matches SRAM_ADDR).
- MAX_ADDR, 20'hFFFFF, last writable address; recording ends after this address is written.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous audio input.

Ports:
- i_clk, input, 1, system clock (12 MHz; also drives AUD_XCK).
- i_rst, input, 1, asynchronous active-high reset.
- i_start, input, 1, one-cycle pulse: start a new recording, or resume if paused.
- i_pause, input, 1, one-cycle pulse: pause recording.
- i_stop, input, 1, one-cycle pulse: stop recording.
- i_aud_bclk, input, 1, codec bit clock (asynchronous).
- i_aud_lrc, input, 1, codec ADCLRCK (asynchronous); low = left channel.
- i_aud_adcdat, input, 1, codec serial ADC data (asynchronous).
- o_data, output, DATA_W, last completed left sample.
- o_address, output, ADDR_W, SRAM address for o_data.
- o_valid, output, 1, one-cycle write strobe.
- o_len, output, ADDR_W+1, number of samples written in the current recording.
- o_full, output, 1, recording ended because MAX_ADDR was written.
- o_state, output, 3, encoded FSM state for the seven-segment debug display.

Behaviour:
- Reset (asynchronous, i_rst=1): every output, the synchronisers, the shift register and the address clear to 0. State becomes IDLE immediately, including mid-word.
- Input sampling:
  - Each audio input passes through SYNC_STAGES flops.
  - A BCLK rising edge is detected when the synced value is 1 and its previous value was 0.
  - LRC and DAT are sampled only on detected BCLK rises.
  - The BCLK high and low phases must each last at least 2 i_clk cycles; a faster BCLK is out of spec.
- Framing (I2S): a left word starts at the first BCLK rise on which the sampled LRC is 0 and was 1 at the previous BCLK rise. That rise is the delay bit and is ignored. The next 16 rises carry bits 15 down to 0. The right channel is ignored.
- States and o_state encoding: IDLE=0, SYNC=1, SKIP=2, SHIFT=3, HOLD=4, PAUSE=5.
  - IDLE: i_start clears o_address, o_len and o_full, then goes to SYNC.
  - SYNC: waits for an LRC 1->0 transition at a BCLK rise, then goes to SKIP. The transition rise is the delay bit itself, so SKIP is exited on that same detection; SKIP is a one-cycle bookkeeping state that clears the bit counter.
  - SHIFT: shifts the sampled DAT into the LSB at each BCLK rise. When the 16th bit arrives, o_data is loaded with the full word and o_valid is pulsed for exactly 1 cycle in the cycle after that rise, then the FSM goes to HOLD.
  - HOLD: in the cycle after o_valid, o_address increments and o_len increments. If the just-written address equals MAX_ADDR, o_full is set, o_address is not incremented, and the FSM goes to IDLE. Otherwise it returns to SYNC.
  - PAUSE: i_start goes to SYNC, keeping o_address and o_len.
- Pause and stop:
  - i_pause in SYNC, SKIP or SHIFT goes to PAUSE; a partial word is discarded and no strobe is issued.
  - i_stop in any non-IDLE state goes to IDLE; a partial word is discarded, and o_len and o_full keep their values.
- Priority of coincident pulses: stop > pause > start.
  - i_start while recording is ignored.
  - i_pause in IDLE or PAUSE is ignored.
  - A pulse arriving in the same cycle as the o_valid strobe does not cancel that strobe; the write completes, then the control action applies.
- Outputs: o_data and o_address hold their values between strobes. o_valid is never high for 2 consecutive cycles.
- Throughput: at most 1 strobe per LRC frame.

Test Plan:
- Reset mid-word: assert i_rst during bit 7 of a word -> all outputs 0 in the same cycle, o_state=0, no o_valid.
- Basic capture: i_start, then 3 I2S frames with left=16'hA5C3, 16'h0001, 16'h8000 and right=16'hFFFF -> 3 strobes; o_data equals each left value in turn; o_address=0,1,2; o_len=3; right data never appears.
- Delay-bit alignment: left word 16'h7FFF with DAT=1 on the delay bit -> captured 16'h7FFF, not 16'hFFFF.
- Pause/resume: i_pause after bit 5 of the second word -> no strobe; o_state=5; o_len=1. Then i_start -> the next complete left word is written at address 1.
- Full boundary: MAX_ADDR=20'd3, record 5 frames -> strobes at addresses 0..3, o_full=1, o_state=0, o_len=4, no 5th strobe.
- Coincident pulses: i_stop and i_pause in the same cycle mid-word -> IDLE; i_start and i_pause in IDLE -> SYNC. A stop pulse in the o_valid cycle -> the strobe is issued, o_len is incremented, then the FSM is IDLE.
